// File: rtl/valid_adder_if.sv
// Operand/result bundle for valid_adder: the stimulus side drives a, b and the
// valid strobe, and the adder returns the registered sum on c.
interface valid_adder_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 7
);
   logic [IN_W-1:0]  a;
   logic [IN_W-1:0]  b;
   logic             valid;
   logic [OUT_W-1:0] c;

   modport master (
      output a,
      output b,
      output valid,
      input  c
   );

   modport slave (
      input  a,
      input  b,
      input  valid,
      output c
   );
endinterface

// File: rtl/valid_adder.sv
// Registered unsigned adder: captures a+b into c on a valid beat, holds otherwise.
// Synchronous active-low reset clears c and takes priority over valid.
module valid_adder #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 7
) (
   input  logic         clk,
   input  logic         reset,
   valid_adder_if.slave bus
);

   // The result must hold the full carry, so the sum can never wrap.
   if (IN_W < 1) begin : g_bad_in_w
      $error("valid_adder: IN_W must be at least 1");
   end
   if (OUT_W < IN_W + 1) begin : g_bad_out_w
      $error("valid_adder: OUT_W must be at least IN_W+1");
   end

   logic [OUT_W-1:0] sum;
   logic [OUT_W-1:0] c_q;

   always_comb begin
      sum = OUT_W'(bus.a) + OUT_W'(bus.b);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         c_q <= '0;
      end else if (bus.valid) begin
         c_q <= sum;
      end
   end

   assign bus.c = c_q;

   // An unknown strobe outside reset would silently corrupt or freeze c.
   a_valid_known: assert property (@(posedge clk) reset |-> !$isunknown(bus.valid))
      else $error("valid_adder: valid is X/Z while out of reset");

endmodule

// File: tb/tb_valid_adder.sv
// Directed and random checks of valid_adder with hand-computed expectations
// and a one-register reference model for the random phase.
module tb_valid_adder;

   localparam int IN_W  = 4;
   localparam int OUT_W = 7;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   logic [OUT_W-1:0] model_c;

   valid_adder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   valid_adder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [OUT_W-1:0] observed,
                        input logic [OUT_W-1:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Apply one beat away from the edge, then sample just after the edge.
   task automatic beat(input logic r, input logic v, input logic [IN_W-1:0] x,
                       input logic [IN_W-1:0] y);
      @(negedge clk);
      reset     = r;
      bus.valid = v;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      bus.valid  = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      model_c    = '0;

      // Reset wins over a valid beat
      beat(1'b0, 1'b1, 4'd9, 4'd3);
      check("reset_cyc1", bus.c, 7'd0);
      beat(1'b0, 1'b1, 4'd9, 4'd3);
      check("reset_cyc2", bus.c, 7'd0);

      // Basic capture and hold
      beat(1'b1, 1'b0, 4'd6, 4'd6);
      check("idle_after_reset", bus.c, 7'd0);
      beat(1'b1, 1'b1, 4'd4, 4'd5);
      check("basic_4p5", bus.c, 7'd9);
      beat(1'b1, 1'b0, 4'd1, 4'd1);
      check("hold_1", bus.c, 7'd9);
      beat(1'b1, 1'b0, 4'd15, 4'd0);
      check("hold_2", bus.c, 7'd9);

      // Maximum operands
      beat(1'b1, 1'b1, 4'd15, 4'd15);
      check("max_sum", bus.c, 7'd30);
      check("max_bit4", 7'(bus.c[4]), 7'd1);
      check("max_bits65", 7'(bus.c[6:5]), 7'd0);

      // Back-to-back beats
      beat(1'b1, 1'b1, 4'd1, 4'd2);
      check("stream_0", bus.c, 7'd3);
      beat(1'b1, 1'b1, 4'd7, 4'd8);
      check("stream_1", bus.c, 7'd15);
      beat(1'b1, 1'b1, 4'd0, 4'd0);
      check("stream_2", bus.c, 7'd0);

      // Reset in the middle of traffic
      beat(1'b1, 1'b1, 4'd5, 4'd7);
      check("pre_reset_12", bus.c, 7'd12);
      beat(1'b0, 1'b1, 4'd2, 4'd2);
      check("midop_reset", bus.c, 7'd0);
      beat(1'b1, 1'b1, 4'd2, 4'd2);
      check("post_reset_4", bus.c, 7'd4);

      // Random traffic against the reference register
      model_c = 7'd4;
      for (int i = 0; i < 1000; i++) begin
         logic r, v;
         logic [IN_W-1:0] x, y;
         r = ($urandom_range(0, 19) != 0);
         v = $urandom_range(0, 1) == 1;
         x = IN_W'($urandom_range(0, 15));
         y = IN_W'($urandom_range(0, 15));
         beat(r, v, x, y);
         if (!r)
            model_c = '0;
         else if (v)
            model_c = OUT_W'(x) + OUT_W'(y);
         check("random", bus.c, model_c);
         if (i % 50 == 0)
            check("random_upper", 7'(bus.c[6:5]), 7'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
